// File: rtl/debug_retire_buf.sv
// Retirement trace buffer: filters WB retire records and queues them for the debug sink.
// Optional build macro DEBUG_RETIRE_BYPASS_EN: an empty FIFO forwards straight to the output register.
module debug_retire_buf #(
    parameter int unsigned DEPTH     = 8,
    parameter bit          FILTER_X0 = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ret_valid,
    input  logic [37:0]                ret_inst,
    input  logic [31:0]                ret_pc,
    input  logic                       ret_write_reg,
    input  logic [4:0]                 ret_reg_id,
    input  logic [31:0]                ret_reg_data,
    input  logic                       ret_write_mem,
    input  logic [31:0]                ret_mem_addr,
    input  logic [31:0]                ret_mem_data,
    input  logic                       drain_en,
    input  logic                       clr_overflow,
    output logic [37:0]                debug_inst,
    output logic [31:0]                debug_pc_cur,
    output logic                       debug_write_reg,
    output logic [4:0]                 debug_reg_id,
    output logic [31:0]                debug_reg_data,
    output logic                       debug_write_mem,
    output logic [31:0]                debug_mem_addr,
    output logic [31:0]                debug_mem_data,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned BC_W  = $clog2(DEPTH + 1);
    localparam int unsigned REC_W = 38 + 32 + 1 + 5 + 32 + 1 + 32 + 32;

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             eff_reg_c;
    logic             accept_c;
    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             bypass_c;
    logic             push_c;
    logic             drop_c;
    logic             load_c;
    logic [REC_W-1:0] in_rec_c;
    logic [REC_W-1:0] load_rec_c;

    // Filter, FIFO control and output-source selection
    always_comb begin
        eff_reg_c  = ret_write_reg && !(FILTER_X0 && (ret_reg_id == 5'd0));
        accept_c   = ret_valid && (eff_reg_c || ret_write_mem);
        in_rec_c   = {ret_inst, ret_pc, eff_reg_c, ret_reg_id, ret_reg_data,
                      ret_write_mem, ret_mem_addr, ret_mem_data};
        empty_c    = (buf_count == BC_W'(0));
        full_c     = (buf_count == BC_W'(DEPTH));
        pop_c      = drain_en && !empty_c;
`ifdef DEBUG_RETIRE_BYPASS_EN
        bypass_c   = accept_c && drain_en && empty_c;
`else
        bypass_c   = 1'b0;
`endif
        // A full FIFO still accepts when the head leaves in the same cycle
        push_c     = accept_c && !bypass_c && (!full_c || pop_c);
        drop_c     = accept_c && !bypass_c && full_c && !pop_c;
        load_c     = pop_c || bypass_c;
        load_rec_c = pop_c ? mem[rd_ptr] : in_rec_c;
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_rec_c;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            buf_count <= buf_count + BC_W'(push_c) - BC_W'(pop_c);
        end
    end

    // Output register: flags pulse for one cycle, data holds between records
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_inst      <= '0;
            debug_pc_cur    <= '0;
            debug_write_reg <= 1'b0;
            debug_reg_id    <= '0;
            debug_reg_data  <= '0;
            debug_write_mem <= 1'b0;
            debug_mem_addr  <= '0;
            debug_mem_data  <= '0;
        end else if (load_c) begin
            {debug_inst, debug_pc_cur, debug_write_reg, debug_reg_id, debug_reg_data,
             debug_write_mem, debug_mem_addr, debug_mem_data} <= load_rec_c;
        end else begin
            debug_write_reg <= 1'b0;
            debug_write_mem <= 1'b0;
        end
    end

    // A drop coinciding with a clear restarts the count at one
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_c) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_cnt <= CNT_W'(1);
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end else if (clr_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_debug_retire_buf.sv
// Randomized scoreboard bench for debug_retire_buf against a queue-based reference model.
module tb_debug_retire_buf;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned REC_W = 173;
`ifdef DEBUG_RETIRE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int unsigned LAT = BYP ? 1 : 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ret_valid = 1'b0;
    logic [37:0]      ret_inst = '0;
    logic [31:0]      ret_pc = '0;
    logic             ret_write_reg = 1'b0;
    logic [4:0]       ret_reg_id = '0;
    logic [31:0]      ret_reg_data = '0;
    logic             ret_write_mem = 1'b0;
    logic [31:0]      ret_mem_addr = '0;
    logic [31:0]      ret_mem_data = '0;
    logic             drain_en = 1'b0;
    logic             clr_overflow = 1'b0;
    logic [37:0]      debug_inst;
    logic [31:0]      debug_pc_cur;
    logic             debug_write_reg;
    logic [4:0]       debug_reg_id;
    logic [31:0]      debug_reg_data;
    logic             debug_write_mem;
    logic [31:0]      debug_mem_addr;
    logic [31:0]      debug_mem_data;
    logic [3:0]       buf_count;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    debug_retire_buf #(.DEPTH(DEPTH), .FILTER_X0(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_inst(ret_inst), .ret_pc(ret_pc),
        .ret_write_reg(ret_write_reg), .ret_reg_id(ret_reg_id), .ret_reg_data(ret_reg_data),
        .ret_write_mem(ret_write_mem), .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data),
        .drain_en(drain_en), .clr_overflow(clr_overflow),
        .debug_inst(debug_inst), .debug_pc_cur(debug_pc_cur), .debug_write_reg(debug_write_reg),
        .debug_reg_id(debug_reg_id), .debug_reg_data(debug_reg_data),
        .debug_write_mem(debug_write_mem), .debug_mem_addr(debug_mem_addr),
        .debug_mem_data(debug_mem_data), .buf_count(buf_count), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [REC_W-1:0] rec;
        int               due;
    } exp_t;

    exp_t             exp_q[$];
    logic [REC_W-1:0] mq[$];
    logic             m_ovf = 1'b0;
    logic [CNT_W-1:0] m_drop = '0;
    int               cyc = 0;
    int               total = 0;
    int               bad = 0;
    logic             rst_seen = 1'b0;

    function automatic logic [REC_W-1:0] out_rec();
        return {debug_inst, debug_pc_cur, debug_write_reg, debug_reg_id, debug_reg_data,
                debug_write_mem, debug_mem_addr, debug_mem_data};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one step per clock edge, using the inputs present at that edge
    task automatic model_step();
        logic             eff;
        logic             acc;
        logic [REC_W-1:0] rec;
        exp_t             e;
        rst_seen = rst;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_ovf  = 1'b0;
            m_drop = '0;
            return;
        end
        eff = ret_write_reg && (ret_reg_id != 5'd0);
        acc = ret_valid && (eff || ret_write_mem);
        rec = {ret_inst, ret_pc, eff, ret_reg_id, ret_reg_data,
               ret_write_mem, ret_mem_addr, ret_mem_data};
        if (BYP && acc && drain_en && mq.size() == 0) begin
            e.rec = rec; e.due = cyc;
            exp_q.push_back(e);
            if (clr_overflow) begin m_ovf = 1'b0; m_drop = '0; end
            return;
        end
        if (drain_en && mq.size() > 0) begin
            e.rec = mq.pop_front(); e.due = cyc;
            exp_q.push_back(e);
        end
        if (acc && mq.size() < DEPTH) begin
            mq.push_back(rec);
            if (clr_overflow) begin m_ovf = 1'b0; m_drop = '0; end
        end else if (acc) begin
            m_ovf = 1'b1;
            if (clr_overflow) m_drop = CNT_W'(1);
            else if (m_drop != '1) m_drop = m_drop + CNT_W'(1);
        end else if (clr_overflow) begin
            m_ovf  = 1'b0;
            m_drop = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        if (rst_seen) check("reset_outputs", 64'(out_rec() != '0), 64'd0);
        check("buf_count", 64'(buf_count), 64'(mq.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic set_ret(input logic v, input logic wr, input logic [4:0] rid,
                           input logic [31:0] rd, input logic wm, input logic [31:0] ma,
                           input logic [31:0] md, input logic [31:0] pc);
        ret_valid = v; ret_write_reg = wr; ret_reg_id = rid; ret_reg_data = rd;
        ret_write_mem = wm; ret_mem_addr = ma; ret_mem_data = md; ret_pc = pc;
        ret_inst = {6'($urandom), pc};
    endtask

    task automatic idle();
        set_ret(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    // Monitor: every output pulse must match the next expected record, in its cycle
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (debug_write_reg || debug_write_mem) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_pulse @cyc %0d: got pc %0h want no record", cyc, debug_pc_cur);
            end else begin
                e = exp_q.pop_front();
                if (out_rec() !== e.rec || e.due != cyc) begin
                    bad++;
                    $display("FAIL record @cyc %0d: got %0h want %0h due %0d", cyc, out_rec(), e.rec, e.due);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            total++;
            bad++;
            e = exp_q.pop_front();
            $display("FAIL missing_pulse @cyc %0d: got no pulse want %0h", cyc, e.rec);
        end
    end

    initial begin
        int dmode;
        dmode = 3;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic register write path and its latency
        drain_en = 1'b1;
        set_ret(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, 32'h80000004);
        tick();
        idle();
        for (int i = 1; i < int'(LAT); i++) begin
            check("basic_early", 64'(debug_write_reg), 64'd0);
            tick();
        end
        check("basic_wr_reg", 64'(debug_write_reg), 64'd1);
        check("basic_data", 64'(debug_reg_data), 64'hDEADBEEF);
        check("basic_pc", 64'(debug_pc_cur), 64'h80000004);
        check("basic_wr_mem", 64'(debug_write_mem), 64'd0);
        tick();

        // x0 filtering: alone it vanishes, with a store only the store is reported
        set_ret(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 32'd0, 32'd0, 32'h40);
        tick();
        idle();
        tick(); tick();
        check("x0_count", 64'(buf_count), 64'd0);
        set_ret(1'b1, 1'b1, 5'd0, 32'h1234, 1'b1, 32'h100, 32'h55, 32'h44);
        tick();
        idle();
        tick(); tick();

        // Backpressure: fill exactly to DEPTH, then drain in order
        drain_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_ret(1'b1, 1'b1, 5'(i + 1), $urandom, 1'b0, 32'd0, 32'd0, 32'(4 * i));
            tick();
        end
        idle();
        tick();
        check("bp_full", 64'(buf_count), 64'd8);
        check("bp_ovf", 64'(overflow), 64'd0);
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("bp_empty", 64'(buf_count), 64'd0);

        // Overflow: three drops, then clear
        drain_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            set_ret(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'(i), $urandom, 32'h200 + 32'(4 * i));
            tick();
        end
        idle();
        tick();
        check("ovf_count", 64'(buf_count), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drops", 64'(drop_cnt), 64'd3);
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("clr_flag", 64'(overflow), 64'd0);
        check("clr_drops", 64'(drop_cnt), 64'd0);

        // Full with simultaneous push and pop
        drain_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_ret(1'b1, 1'b1, 5'd7, $urandom, 1'b0, 32'd0, 32'd0, 32'h300 + 32'(4 * i));
            tick();
        end
        drain_en = 1'b1;
        set_ret(1'b1, 1'b1, 5'd9, 32'hCAFE, 1'b0, 32'd0, 32'd0, 32'h1000);
        tick();
        idle();
        check("fullpp_count", 64'(buf_count), 64'd8);
        check("fullpp_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 10; i++) tick();

        // Reset mid-drain discards the queue
        drain_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_ret(1'b1, 1'b1, 5'd3, $urandom, 1'b0, 32'd0, 32'd0, 32'h400 + 32'(4 * i));
            tick();
        end
        idle();
        check("rst_pre", 64'(buf_count), 64'd5);
        drain_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_count", 64'(buf_count), 64'd0);
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic with varying drain pressure
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) dmode = $urandom_range(0, 3);
            set_ret($urandom_range(0, 3) != 0, 1'($urandom),
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    $urandom, 1'($urandom), $urandom, $urandom, $urandom);
            drain_en     = (dmode == 0) ? 1'b0 :
                           (dmode == 1) ? ($urandom_range(0, 3) == 0) :
                           (dmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            clr_overflow = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle();
        rst = 1'b0;
        clr_overflow = 1'b0;
        drain_en = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("final_drained", 64'(exp_q.size()), 64'd0);
        check("final_count", 64'(buf_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
